pc_stack_unit: RTL



---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_stack_ret_stack.sv | 58 +++++
 rtl/pc_stack_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program-counter stage: next-PC select encoding and address type.
package pc_pkg;

    localparam int unsigned PC_ADDR_W = 12;

    typedef logic [PC_ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_RET = 2'b01,
        PC_JMP = 2'b10,
        PC_BR  = 2'b11
    } pc_sel_e;

endpackage

// File: rtl/pc_stack_ret_stack.sv
// Return-address LIFO. Top entry is read combinationally from index sp-1.
// A simultaneous push and pop leaves the stack untouched.
module ret_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 12,
    localparam int unsigned SP_W  = $clog2(DEPTH) + 1,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    wr_data,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty,
    output logic [W-1:0]    top
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign wr_idx = sp_q[IDX_W-1:0];
    // Wraps to DEPTH-1 when empty; the value is unused in that case.
    assign rd_idx = IDX_W'(sp_q - 1'b1);

    assign empty = (sp_q == '0);
    assign full  = (sp_q == SP_W'(DEPTH));
    assign sp    = sp_q;
    assign top   = mem_q[rd_idx];

    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        if (push && !pop && !full) begin
            mem_d[wr_idx] = wr_data;
            sp_d          = sp_q + 1'b1;
        end else if (pop && !push && !empty) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage is deliberately not reset; sp alone defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_stack_unit.sv
// PC register, next-PC mux and sticky stack error flags around the return stack.
// All outputs come from registers; no input reaches an output combinationally.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 12,
    parameter int unsigned          OFF_W    = 8,
    parameter int unsigned          DEPTH    = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic [1:0]               pc_state,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_W-1:0]        jmp_addr,
    input  logic [OFF_W-1:0]         br_offset,
    output logic [ADDR_W-1:0]        pc,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     stack_empty,
    output logic                     stack_full,
    output logic                     ovf_err,
    output logic                     unf_err
);

    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc, br_ext, stk_top;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              stk_push, stk_pop;
    logic              illegal;

    assign sel     = pc_sel_e'(pc_state);
    assign pc_inc  = pc_q + 1'b1;
    assign br_ext  = ADDR_W'($signed(br_offset));
    assign illegal = push && pop;

    ret_stack #(
        .DEPTH (DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (stk_push),
        .pop     (stk_pop),
        .wr_data (pc_inc),
        .sp      (sp),
        .full    (stack_full),
        .empty   (stack_empty),
        .top     (stk_top)
    );

    always_comb begin
        pc_d     = pc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (!hold) begin
            case (sel)
                PC_SEQ: pc_d = pc_inc;
                PC_JMP: pc_d = jmp_addr;
                PC_BR:  pc_d = pc_inc + br_ext;
                PC_RET: pc_d = stack_empty ? pc_inc : stk_top;
            endcase
            stk_push = push && !pop;
            stk_pop  = pop && !push;
            if (stk_push && stack_full) ovf_d = 1'b1;
            if (stk_pop && stack_empty) unf_d = 1'b1;
            // A push+pop decode is treated as garbage: it raises no flag at all.
            if ((sel == PC_RET) && stack_empty && !illegal) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc      = pc_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule
